// File: rtl/InstructionSetPkg.sv
// Shared instruction-set types for the ALU and the two-requester arbiter front end.
package InstructionSetPkg;

    localparam int DataWidth      = 16;
    localparam int ImmediateWidth = 8;
    localparam int NumRequesters  = 2;

    // Opcodes 12..15 are intentionally left unassigned: the ALU returns 0
    // for them and leaves the flags untouched.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_ADC  = 4'd1,
        OP_SUB  = 4'd2,
        OP_SBC  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_ADDI = 4'd7,
        OP_ROL  = 4'd8,
        OP_ROR  = 4'd9,
        OP_MOV  = 4'd10,
        OP_LDI  = 4'd11
    } eOperation;

    // Carry doubles as "borrow" for the subtract family.
    typedef struct packed {
        logic Zero;
        logic Carry;
        logic Negative;
        logic Overflow;
    } sFlags;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } eArbState;

    function automatic logic [DataWidth-1:0] SignExtendImm(input logic [ImmediateWidth-1:0] imm);
        return {{(DataWidth - ImmediateWidth){imm[ImmediateWidth-1]}}, imm};
    endfunction

endpackage

// File: rtl/ArithmeticLogicUnit.sv
// Purely combinational ALU: computes a new destination value and flag set
// from the destination/source operands, an immediate and the incoming flags.
module ArithmeticLogicUnit
    import InstructionSetPkg::*;
(
    input  eOperation                          Op,
    input  logic signed [DataWidth-1:0]        InSrc,
    input  logic signed [DataWidth-1:0]        InDest,
    input  logic signed [ImmediateWidth-1:0]   InImm,
    input  sFlags                              InFlags,
    output logic signed [DataWidth-1:0]        OutDest,
    output sFlags                              OutFlags
);

    localparam int W = DataWidth;

    logic [W-1:0] w_A;
    logic [W-1:0] w_B;
    logic [W-1:0] w_ImmExt;
    logic [W:0]   w_Sum;
    logic [W-1:0] w_Result;
    logic         w_SetZn;

    assign w_A      = InDest;
    assign w_B      = InSrc;
    assign w_ImmExt = SignExtendImm(InImm);

    // Operation decode; Zero/Negative are derived from the result afterwards
    // for every defined opcode, other flags only where the opcode defines them.
    always_comb begin
        w_Sum    = '0;
        w_Result = '0;
        w_SetZn  = 1'b0;
        OutFlags = InFlags;
        case (Op)
            OP_ADD: begin
                w_Sum             = {1'b0, w_A} + {1'b0, w_B};
                w_Result          = w_Sum[W-1:0];
                OutFlags.Carry    = w_Sum[W];
                OutFlags.Overflow = (w_A[W-1] == w_B[W-1]) && (w_Result[W-1] != w_A[W-1]);
                w_SetZn           = 1'b1;
            end
            OP_ADC: begin
                w_Sum             = {1'b0, w_A} + {1'b0, w_B} + {{W{1'b0}}, InFlags.Carry};
                w_Result          = w_Sum[W-1:0];
                OutFlags.Carry    = w_Sum[W];
                OutFlags.Overflow = (w_A[W-1] == w_B[W-1]) && (w_Result[W-1] != w_A[W-1]);
                w_SetZn           = 1'b1;
            end
            OP_SUB: begin
                w_Sum             = {1'b0, w_A} - {1'b0, w_B};
                w_Result          = w_Sum[W-1:0];
                OutFlags.Carry    = w_Sum[W];
                OutFlags.Overflow = (w_A[W-1] != w_B[W-1]) && (w_Result[W-1] != w_A[W-1]);
                w_SetZn           = 1'b1;
            end
            OP_SBC: begin
                w_Sum             = {1'b0, w_A} - {1'b0, w_B} - {{W{1'b0}}, InFlags.Carry};
                w_Result          = w_Sum[W-1:0];
                OutFlags.Carry    = w_Sum[W];
                OutFlags.Overflow = (w_A[W-1] != w_B[W-1]) && (w_Result[W-1] != w_A[W-1]);
                w_SetZn           = 1'b1;
            end
            OP_AND: begin
                w_Result = w_A & w_B;
                w_SetZn  = 1'b1;
            end
            OP_OR: begin
                w_Result = w_A | w_B;
                w_SetZn  = 1'b1;
            end
            OP_XOR: begin
                w_Result = w_A ^ w_B;
                w_SetZn  = 1'b1;
            end
            OP_ADDI: begin
                w_Sum             = {1'b0, w_A} + {1'b0, w_ImmExt};
                w_Result          = w_Sum[W-1:0];
                OutFlags.Carry    = w_Sum[W];
                OutFlags.Overflow = (w_A[W-1] == w_ImmExt[W-1]) && (w_Result[W-1] != w_A[W-1]);
                w_SetZn           = 1'b1;
            end
            OP_ROL: begin
                // Rotate through carry: old carry enters bit 0, MSB leaves to carry.
                w_Result       = {w_A[W-2:0], InFlags.Carry};
                OutFlags.Carry = w_A[W-1];
                w_SetZn        = 1'b1;
            end
            OP_ROR: begin
                w_Result       = {InFlags.Carry, w_A[W-1:1]};
                OutFlags.Carry = w_A[0];
                w_SetZn        = 1'b1;
            end
            OP_MOV: begin
                w_Result = w_B;
                w_SetZn  = 1'b1;
            end
            OP_LDI: begin
                w_Result = w_ImmExt;
                w_SetZn  = 1'b1;
            end
            default: begin
                w_Result = '0;
            end
        endcase
        OutDest = w_Result;
        if (w_SetZn) begin
            OutFlags.Zero     = (w_Result == '0);
            OutFlags.Negative = w_Result[W-1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU: round-robin grant in IDLE,
// one execute cycle, then a held response until the owner consumes it.
// Each requester keeps its own committed flag context.
module alu_arbiter
    import InstructionSetPkg::*;
(
    input  logic                               Clock,
    input  logic                               nReset,
    input  logic [1:0]                         ReqValid,
    output logic [1:0]                         ReqReady,
    input  eOperation                          ReqOp   [2],
    input  logic signed [DataWidth-1:0]        ReqSrc  [2],
    input  logic signed [DataWidth-1:0]        ReqDest [2],
    input  logic signed [ImmediateWidth-1:0]   ReqImm  [2],
    output logic [1:0]                         RspValid,
    input  logic [1:0]                         RspReady,
    output logic signed [DataWidth-1:0]        RspData,
    output sFlags                              FlagsOut [2],
    output logic                               Busy
);

    eArbState                         r_State;
    eArbState                         w_NextState;
    logic                             r_Owner;
    logic                             r_Priority;
    eOperation                        r_Op;
    logic signed [DataWidth-1:0]      r_Src;
    logic signed [DataWidth-1:0]      r_Dest;
    logic signed [ImmediateWidth-1:0] r_Imm;
    logic signed [DataWidth-1:0]      r_Result;
    sFlags                            r_PendFlags;

    logic                             w_Winner;
    logic                             w_Accept;
    logic                             w_Capture;
    logic                             w_Handshake;
    sFlags                            w_InFlags;
    logic signed [DataWidth-1:0]      w_AluDest;
    sFlags                            w_AluFlags;

    // Round-robin pick: a lone requester wins, a tie goes to the priority holder.
    always_comb begin
        w_Winner = 1'b0;
        case (ReqValid)
            2'b01:   w_Winner = 1'b0;
            2'b10:   w_Winner = 1'b1;
            2'b11:   w_Winner = r_Priority;
            default: w_Winner = 1'b0;
        endcase
    end

    // Next-state and per-state strobes for the IDLE -> EXEC -> RESP cycle.
    always_comb begin
        w_NextState = r_State;
        w_Accept    = 1'b0;
        w_Capture   = 1'b0;
        w_Handshake = 1'b0;
        case (r_State)
            IDLE: begin
                if (|ReqValid) begin
                    w_Accept    = 1'b1;
                    w_NextState = EXEC;
                end
            end
            EXEC: begin
                w_Capture   = 1'b1;
                w_NextState = RESP;
            end
            RESP: begin
                // Only the owner's RspReady can retire the operation.
                if (RspReady[r_Owner]) begin
                    w_Handshake = 1'b1;
                    w_NextState = IDLE;
                end
            end
            default: begin
                w_NextState = IDLE;
            end
        endcase
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_State <= IDLE;
        end else begin
            r_State <= w_NextState;
        end
    end

    // Operand latch on accept, result capture in EXEC, priority hand-off on retire.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_Owner     <= 1'b0;
            r_Priority  <= 1'b0;
            r_Op        <= OP_ADD;
            r_Src       <= '0;
            r_Dest      <= '0;
            r_Imm       <= '0;
            r_Result    <= '0;
            r_PendFlags <= '0;
        end else begin
            if (w_Accept) begin
                r_Owner <= w_Winner;
                r_Op    <= ReqOp[w_Winner];
                r_Src   <= ReqSrc[w_Winner];
                r_Dest  <= ReqDest[w_Winner];
                r_Imm   <= ReqImm[w_Winner];
            end
            if (w_Capture) begin
                r_Result    <= w_AluDest;
                r_PendFlags <= w_AluFlags;
            end
            if (w_Handshake) begin
                r_Priority <= ~r_Owner;
            end
        end
    end

    // The owner's committed context feeds the ALU (carry-in for ADC/SBC/rotates).
    assign w_InFlags = FlagsOut[r_Owner];

    ArithmeticLogicUnit u_alu (
        .Op       (r_Op),
        .InSrc    (r_Src),
        .InDest   (r_Dest),
        .InImm    (r_Imm),
        .InFlags  (w_InFlags),
        .OutDest  (w_AluDest),
        .OutFlags (w_AluFlags)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NumRequesters; gi++) begin : g_req
            sFlags r_Flags;

            // Flag context changes only on this requester's own response handshake.
            always_ff @(posedge Clock or negedge nReset) begin
                if (!nReset) begin
                    r_Flags <= '0;
                end else if (w_Handshake && (r_Owner == 1'(gi))) begin
                    r_Flags <= r_PendFlags;
                end
            end

            assign FlagsOut[gi] = r_Flags;
            // Gated with nReset so the accept pulse is suppressed while reset is held.
            assign ReqReady[gi] = nReset && w_Accept && (w_Winner == 1'(gi));
            assign RspValid[gi] = (r_State == RESP) && (r_Owner == 1'(gi));
        end
    endgenerate

    assign RspData = r_Result;
    assign Busy    = (r_State != IDLE);

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have ports: Clock  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: nReset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: ReqValid  in  [1:0]  requester i presents an operation.
REQ-004 SHALL have: ReqReady  out  [1:0]  one-cycle accept pulse to requester i.
REQ-005 SHALL have: ReqOp  in  2 x eOperation  operation per requester.
REQ-006 SHALL have: ReqSrc, ReqDest  in  2 x DataWidth signed  source/destination register values.
REQ-007 SHALL have: ReqImm  in  2 x ImmediateWidth signed  immediate per requester.
REQ-008 SHALL have: RspValid  out  [1:0]  result for requester i held valid.
REQ-009 SHALL have: RspReady  in  [1:0]  requester i consumes result.
REQ-010 SHALL have: RspData  out  DataWidth signed  result value, shared by both requesters.
REQ-011 SHALL have: FlagsOut  out  2 x sFlags  committed flag context per requester.
REQ-012 SHALL have: Busy  out  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-014 IDLE: if any ReqValid, SHALL select a winner, latch its Op/Src/Dest/Imm and owner index, pulse ReqReady[winner] for that cycle only, and go to EXEC.
REQ-015 Arbitration SHALL be round-robin via a Priority bit: single requester wins outright; on simultaneous requests the Priority requester wins.
REQ-016 EXEC: the shared ALU SHALL receive the latched operands plus FlagsOut[owner] as InFlags; OutDest and OutFlags SHALL be registered into result/pending-flag registers; next state RESP.
REQ-017 RESP: RspValid[owner] SHALL be 1 and RspData stable until RspReady[owner] is high; the other RspValid bit SHALL be 0.
REQ-018 On RESP handshake SHALL copy the pending flags into FlagsOut[owner], set Priority to the non-owner, and return to IDLE.
REQ-019 RspReady while RspValid is low, and RspReady of the non-owner, SHALL be ignored.
REQ-020 Latency: accept at edge N; RspValid high from edge N+2; minimum 3 cycles per operation.
REQ-021 ReqValid changes after acceptance SHALL NOT affect the in-flight operation; ReqReady SHALL never be asserted outside IDLE.
REQ-022 FlagsOut of the non-owner SHALL never change during another requester's operation.
REQ-023 Undefined ALU operations SHALL produce RspData 0 and flags unchanged, as the ALU defines.

Reset
REQ-024 nReset low SHALL immediately force state IDLE, ReqReady 0, RspValid 0, RspData 0, both FlagsOut all-zero, Priority to requester 0, Busy 0.
REQ-025 Reset mid-operation SHALL abandon the operation with no response and no flag commit.
REQ-026 Deassertion SHALL be safe; first accept no earlier than first rising edge after release.

Structure
REQ-027 eOperation, sFlags, DataWidth, ImmediateWidth SHALL come from InstructionSetPkg; the FSM state enum SHALL be added to that package as eArbState.
REQ-028 SHALL instantiate exactly one ArithmeticLogicUnit as its single sub-module; no other arithmetic in this block.

Verification
REQ-029 Reset then ReqValid=01, ADC Src=5 Dest=3 carry 0 -> ReqReady=01 one cycle, RspValid=01 two cycles later, RspData=8, FlagsOut[0].Zero=0 after handshake.
REQ-030 Both ReqValid=11 continuously after reset -> grants alternate 0,1,0,1; each RspValid bit only for its own owner.
REQ-031 Requester 1 SUB Dest=3 Src=3 -> RspData=0, FlagsOut[1].Zero=1, FlagsOut[0] unchanged.
REQ-032 Hold RspReady low 5 cycles in RESP -> RspValid and RspData stable, Busy=1, no new ReqReady; release -> IDLE next cycle.
REQ-033 Requester 0 ROL with FlagsOut[0].Carry=1 -> ALU sees Carry=1; result bit 0 = 1.
REQ-034 Assert nReset low during EXEC -> RspValid stays 0, FlagsOut both zero, next grant to requester 0.
